snake_engine: RTL and testbench

Parametrised successor to the snake body unit. Holds the snake body in a circular position buffer with a variable length. On each `step` it moves the head one cell, with optional growth and a choice of wrap-around or wall-kill edges. It rejects 180° reversals and detects self-collision with a sequential body scan. A registered random-access read port feeds the VGA renderer, and the game FSM drives `step` and `grow`.

---
 rtl/snake_pkg.sv | 31 +++
 rtl/snake_engine_if.sv | 35 +++
 rtl/snake_ring.sv | 73 +++++++
 rtl/snake_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_snake_engine.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake body engine.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_RIGHT = 2'd0;
  localparam dir_t DIR_UP    = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_DOWN  = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_DEAD   = 2'd3;

  // Bits needed to hold values 0..n-1 (minimum 1).
  function automatic int logb2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Reverse direction: the encoding places opposites two apart.
  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_engine_if.sv
// Control, status and renderer read bus of the snake engine.
interface snake_engine_if #(
  parameter int XW = 5,
  parameter int YW = 5,
  parameter int LW = 7
);
  logic          dir_valid;
  logic [1:0]    dir;
  logic          step;
  logic          grow;
  logic          busy;
  logic          done;
  logic          dead;
  logic          self_col;
  logic          wall_col;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] length;
  logic [LW-1:0] rd_idx;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          rd_valid;

  modport master (
    output dir_valid, dir, step, grow, rd_idx,
    input  busy, done, dead, self_col, wall_col, head_x, head_y, length,
           rd_x, rd_y, rd_valid
  );

  modport slave (
    input  dir_valid, dir, step, grow, rd_idx,
    output busy, done, dead, self_col, wall_col, head_x, head_y, length,
           rd_x, rd_y, rd_valid
  );
endinterface

// File: rtl/snake_ring.sv
// Circular body buffer: segment i lives in slot (head_ptr + i) mod MAX_LEN.
// A write pre-decrements the head pointer so the new head becomes segment 0
// and every old segment shifts down by one index without moving data.
module snake_ring
  import snake_pkg::*;
#(
  parameter int H        = 32,
  parameter int V        = 32,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int XW       = 5,
  parameter int YW       = 5,
  parameter int LW       = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [XW-1:0] wx_i,
  input  logic [YW-1:0] wy_i,
  input  logic [LW-1:0] scan_idx_i,
  output logic [XW-1:0] scan_x_o,
  output logic [YW-1:0] scan_y_o,
  input  logic [LW-1:0] rd_idx_i,
  output logic [XW-1:0] rd_x_o,
  output logic [YW-1:0] rd_y_o
);
  localparam int PW = logb2(MAX_LEN);

  logic [XW-1:0] mx_q [MAX_LEN];
  logic [YW-1:0] my_q [MAX_LEN];
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_dec;
  logic [PW-1:0] scan_slot;
  logic [PW-1:0] rd_slot;

  // Segment index to buffer slot; out-of-range indices fold to slot 0.
  function automatic logic [PW-1:0] slot_of(input logic [PW-1:0] ptr,
                                            input logic [LW-1:0] idx);
    logic [LW:0] sum;
    sum = {{(LW + 1 - PW){1'b0}}, ptr} + {1'b0, idx};
    if (sum >= (LW + 1)'(MAX_LEN)) sum = sum - (LW + 1)'(MAX_LEN);
    if (sum >= (LW + 1)'(MAX_LEN)) sum = '0;
    return sum[PW-1:0];
  endfunction

  assign ptr_dec   = (ptr_q == '0) ? PW'(MAX_LEN - 1) : ptr_q - PW'(1);
  assign scan_slot = slot_of(ptr_q, scan_idx_i);
  assign rd_slot   = slot_of(ptr_q, rd_idx_i);

  // Combinational read ports for the collision scan and the renderer.
  always_comb begin
    scan_x_o = mx_q[scan_slot];
    scan_y_o = my_q[scan_slot];
    rd_x_o   = mx_q[rd_slot];
    rd_y_o   = my_q[rd_slot];
  end

  // Reset loads the initial horizontal body; a write pushes a new head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        mx_q[i] <= (i < INIT_LEN) ? XW'(H / 2 - i) : '0;
        my_q[i] <= (i < INIT_LEN) ? YW'(V / 2) : '0;
      end
    end else if (we_i) begin
      ptr_q          <= ptr_dec;
      mx_q[ptr_dec]  <= wx_i;
      my_q[ptr_dec]  <= wy_i;
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake body engine: direction filter, move FSM with sequential self-collision
// scan, wall/wrap edge handling and a registered renderer read port.
//
// state  | meaning
// IDLE   | waiting for step
// SCAN   | comparing new head against one body segment per cycle
// COMMIT | writing new head, updating length and direction
// DEAD   | collision recorded, only reset leaves
module snake_engine
  import snake_pkg::*;
#(
  parameter int H        = 32,
  parameter int V        = 32,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int WRAP     = 1
) (
  input  logic clk,
  input  logic reset,
  snake_engine_if.slave sif
);
  localparam int XW = logb2(H);
  localparam int YW = logb2(V);
  localparam int LW = logb2(MAX_LEN + 1);

  logic [1:0]    state_q, state_d;
  dir_t          cur_dir_q, cur_dir_d;
  dir_t          pend_dir_q, pend_dir_d;
  dir_t          mv_dir_q, mv_dir_d;
  logic          grow_q, grow_d;
  logic          wall_hit_q, wall_hit_d;
  logic [XW-1:0] nx_q, nx_d, hx_q, hx_d;
  logic [YW-1:0] ny_q, ny_d, hy_q, hy_d;
  logic [LW-1:0] cnt_q, cnt_d, n_q, n_d, len_q, len_d;
  logic          done_q, done_d, dead_q, dead_d;
  logic          self_q, self_d, wallc_q, wallc_d;
  logic [XW-1:0] rd_x_q;
  logic [YW-1:0] rd_y_q;
  logic          rd_valid_q;

  logic          we;
  logic [XW-1:0] scan_x, ring_rd_x, cand_x;
  logic [YW-1:0] scan_y, ring_rd_y, cand_y;
  logic          cand_oob;
  logic          grow_eff;
  logic [LW-1:0] scan_n;
  logic          rd_hit;

  snake_ring #(
    .H(H), .V(V), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN),
    .XW(XW), .YW(YW), .LW(LW)
  ) u_ring (
    .clk        (clk),
    .reset      (reset),
    .we_i       (we),
    .wx_i       (nx_q),
    .wy_i       (ny_q),
    .scan_idx_i (cnt_q),
    .scan_x_o   (scan_x),
    .scan_y_o   (scan_y),
    .rd_idx_i   (sif.rd_idx),
    .rd_x_o     (ring_rd_x),
    .rd_y_o     (ring_rd_y)
  );

  // Candidate head one cell along the pending direction, with edge check.
  always_comb begin
    cand_x   = hx_q;
    cand_y   = hy_q;
    cand_oob = 1'b0;
    case (pend_dir_q)
      DIR_RIGHT: begin
        cand_x   = hx_q + XW'(1);
        cand_oob = (WRAP == 0) && (hx_q == XW'(H - 1));
      end
      DIR_LEFT: begin
        cand_x   = hx_q - XW'(1);
        cand_oob = (WRAP == 0) && (hx_q == '0);
      end
      DIR_UP: begin
        cand_y   = hy_q + YW'(1);
        cand_oob = (WRAP == 0) && (hy_q == YW'(V - 1));
      end
      default: begin
        cand_y   = hy_q - YW'(1);
        cand_oob = (WRAP == 0) && (hy_q == '0);
      end
    endcase
  end

  // Growth is dropped at full length; the tail cell is skipped on plain moves.
  assign grow_eff = sif.grow && (len_q < LW'(MAX_LEN));
  assign scan_n   = grow_eff ? len_q : len_q - LW'(1);

  // Move FSM and direction filter next-state logic.
  always_comb begin
    state_d    = state_q;
    cur_dir_d  = cur_dir_q;
    pend_dir_d = pend_dir_q;
    mv_dir_d   = mv_dir_q;
    grow_d     = grow_q;
    wall_hit_d = wall_hit_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    hx_d       = hx_q;
    hy_d       = hy_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    len_d      = len_q;
    done_d     = 1'b0;
    dead_d     = dead_q;
    self_d     = self_q;
    wallc_d    = wallc_q;
    we         = 1'b0;

    if (sif.dir_valid && (sif.dir != opposite(cur_dir_q))) pend_dir_d = sif.dir;

    case (state_q)
      ST_IDLE: begin
        if (sif.step) begin
          mv_dir_d   = pend_dir_q;
          grow_d     = grow_eff;
          nx_d       = cand_x;
          ny_d       = cand_y;
          wall_hit_d = cand_oob;
          cnt_d      = '0;
          n_d        = scan_n;
          state_d    = (cand_oob || (scan_n != '0)) ? ST_SCAN : ST_COMMIT;
        end
      end
      ST_SCAN: begin
        if (wall_hit_q) begin
          wallc_d = 1'b1;
          dead_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DEAD;
        end else if ((scan_x == nx_q) && (scan_y == ny_q)) begin
          self_d  = 1'b1;
          dead_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DEAD;
        end else begin
          cnt_d = cnt_q + LW'(1);
          if (cnt_q == n_q - LW'(1)) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        we        = 1'b1;
        hx_d      = nx_q;
        hy_d      = ny_q;
        cur_dir_d = mv_dir_q;
        if (grow_q) len_d = len_q + LW'(1);
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_DEAD;
    endcase
  end

  // FSM, committed head/length and sticky status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cur_dir_q  <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      mv_dir_q   <= DIR_RIGHT;
      grow_q     <= 1'b0;
      wall_hit_q <= 1'b0;
      nx_q       <= '0;
      ny_q       <= '0;
      hx_q       <= XW'(H / 2);
      hy_q       <= YW'(V / 2);
      cnt_q      <= '0;
      n_q        <= '0;
      len_q      <= LW'(INIT_LEN);
      done_q     <= 1'b0;
      dead_q     <= 1'b0;
      self_q     <= 1'b0;
      wallc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_dir_q  <= cur_dir_d;
      pend_dir_q <= pend_dir_d;
      mv_dir_q   <= mv_dir_d;
      grow_q     <= grow_d;
      wall_hit_q <= wall_hit_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      hx_q       <= hx_d;
      hy_q       <= hy_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      len_q      <= len_d;
      done_q     <= done_d;
      dead_q     <= dead_d;
      self_q     <= self_d;
      wallc_q    <= wallc_d;
    end
  end

  assign rd_hit = (sif.rd_idx < len_q);

  // Renderer port: one-cycle registered read, zeroed past the body end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_hit;
      rd_x_q     <= rd_hit ? ring_rd_x : '0;
      rd_y_q     <= rd_hit ? ring_rd_y : '0;
    end
  end

  assign sif.busy     = (state_q == ST_SCAN) || (state_q == ST_COMMIT);
  assign sif.done     = done_q;
  assign sif.dead     = dead_q;
  assign sif.self_col = self_q;
  assign sif.wall_col = wallc_q;
  assign sif.head_x   = hx_q;
  assign sif.head_y   = hy_q;
  assign sif.length   = len_q;
  assign sif.rd_x     = rd_x_q;
  assign sif.rd_y     = rd_y_q;
  assign sif.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: default, MAX_LEN=4 and WRAP=0 instances
// share one stimulus stream.
module tb_snake_engine;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dir_valid = 1'b0;
  logic [1:0] dir = 2'd0;
  logic       step = 1'b0;
  logic       grow = 1'b0;
  int         ridx = 0;

  always #5 clk = ~clk;

  snake_engine_if #(.XW(5), .YW(5), .LW(7)) if_m ();
  snake_engine_if #(.XW(5), .YW(5), .LW(3)) if_4 ();
  snake_engine_if #(.XW(5), .YW(5), .LW(7)) if_w ();

  assign if_m.dir_valid = dir_valid;
  assign if_m.dir       = dir;
  assign if_m.step      = step;
  assign if_m.grow      = grow;
  assign if_m.rd_idx    = 7'(ridx);
  assign if_4.dir_valid = dir_valid;
  assign if_4.dir       = dir;
  assign if_4.step      = step;
  assign if_4.grow      = grow;
  assign if_4.rd_idx    = 3'(ridx);
  assign if_w.dir_valid = dir_valid;
  assign if_w.dir       = dir;
  assign if_w.step      = step;
  assign if_w.grow      = grow;
  assign if_w.rd_idx    = 7'(ridx);

  snake_engine u_m (.clk(clk), .reset(reset), .sif(if_m));
  snake_engine #(.MAX_LEN(4)) u_4 (.clk(clk), .reset(reset), .sif(if_4));
  snake_engine #(.WRAP(0)) u_w (.clk(clk), .reset(reset), .sif(if_w));

  int n_vec = 0;
  int n_err = 0;
  int lat_done, n_done, lat_wall;
  bit busy0;

  typedef struct {
    int idx; int v; int x; int y;
  } rd_vec_t;

  typedef struct {
    int d; int g; int ex; int ey; int elen;
  } stp_vec_t;

  rd_vec_t  rtab [4];
  stp_vec_t stab [6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step = 1'b0;
    grow = 1'b0;
    dir_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic set_dir(input int d);
    dir_valid = 1'b1;
    dir = 2'(d);
    tick();
    dir_valid = 1'b0;
  endtask

  task automatic sample(input int lat, input bit wall0);
    if (if_m.done) begin
      n_done++;
      if (lat_done < 0) lat_done = lat;
    end
    if (!wall0 && if_w.wall_col && lat_wall < 0) lat_wall = lat;
  endtask

  // Pulse step for one cycle, then follow all instances until idle.
  task automatic do_step(input bit g);
    int lat;
    bit wall0;
    wall0 = if_w.wall_col;
    lat_done = -1;
    n_done = 0;
    lat_wall = -1;
    step = 1'b1;
    grow = g;
    tick();
    step = 1'b0;
    grow = 1'b0;
    lat = 0;
    busy0 = if_m.busy;
    sample(lat, wall0);
    while ((if_m.busy || if_4.busy || if_w.busy) && lat < 100) begin
      tick();
      lat++;
      sample(lat, wall0);
    end
    if (lat >= 100) check("step_timeout", lat, 0);
  endtask

  task automatic check_reset_image(input string tag);
    foreach (rtab[k]) begin
      ridx = rtab[k].idx;
      tick();
      check({tag, "_valid"}, int'(if_m.rd_valid), rtab[k].v);
      check({tag, "_x"}, int'(if_m.rd_x), rtab[k].x);
      check({tag, "_y"}, int'(if_m.rd_y), rtab[k].y);
    end
  endtask

  initial begin
    rtab = '{'{0, 1, 16, 16}, '{1, 1, 15, 16}, '{2, 1, 14, 16}, '{3, 0, 0, 0}};
    stab = '{'{DIR_RIGHT, 0, 17, 16, 3},
             '{DIR_LEFT,  0, 18, 16, 3},
             '{DIR_UP,    0, 18, 17, 3},
             '{DIR_RIGHT, 1, 19, 17, 4},
             '{DIR_DOWN,  1, 19, 16, 5},
             '{DIR_UP,    0, 19, 15, 5}};

    // Reset state, sampled while reset is held.
    tick();
    tick();
    check("rst_head_x", int'(if_m.head_x), 16);
    check("rst_head_y", int'(if_m.head_y), 16);
    check("rst_length", int'(if_m.length), 3);
    check("rst_busy", int'(if_m.busy), 0);
    check("rst_done", int'(if_m.done), 0);
    check("rst_dead", int'(if_m.dead), 0);
    check("rst_self", int'(if_m.self_col), 0);
    check("rst_wall", int'(if_w.wall_col), 0);
    check("rst_rd_valid", int'(if_m.rd_valid), 0);
    check("rst_rd_x", int'(if_m.rd_x), 0);
    reset = 1'b1;
    tick();

    // Renderer sweep of the reset body.
    check_reset_image("sweep");
    for (int i = 4; i < 64; i++) begin
      ridx = i;
      tick();
      check("sweep_tail_valid", int'(if_m.rd_valid), 0);
      check("sweep_tail_x", int'(if_m.rd_x), 0);
    end
    ridx = 0;

    // First move: latency N+1 = 3.
    do_reset();
    do_step(1'b0);
    check("mv1_busy_after_step", int'(busy0), 1);
    check("mv1_done_latency", lat_done, 3);
    check("mv1_done_count", n_done, 1);
    check("mv1_head_x", int'(if_m.head_x), 17);
    check("mv1_head_y", int'(if_m.head_y), 16);
    check("mv1_length", int'(if_m.length), 3);
    check("mv1_busy_end", int'(if_m.busy), 0);

    // Turn up straight from reset.
    do_reset();
    set_dir(DIR_UP);
    do_step(1'b0);
    check("up_head_x", int'(if_m.head_x), 16);
    check("up_head_y", int'(if_m.head_y), 17);

    // Table of direction requests, reversals and growth.
    do_reset();
    foreach (stab[k]) begin
      set_dir(stab[k].d);
      do_step(stab[k].g[0]);
      check("tab_head_x", int'(if_m.head_x), stab[k].ex);
      check("tab_head_y", int'(if_m.head_y), stab[k].ey);
      check("tab_length", int'(if_m.length), stab[k].elen);
      check("tab_done_count", n_done, 1);
    end

    // Five growing steps; the MAX_LEN=4 copy saturates and slides its tail.
    do_reset();
    for (int i = 0; i < 5; i++) do_step(1'b1);
    check("grow_length", int'(if_m.length), 8);
    check("grow_head_x", int'(if_m.head_x), 21);
    check("ml4_length", int'(if_4.length), 4);
    check("ml4_head_x", int'(if_4.head_x), 21);
    ridx = 3;
    tick();
    check("ml4_seg3_valid", int'(if_4.rd_valid), 1);
    check("ml4_seg3_x", int'(if_4.rd_x), 18);
    ridx = 4;
    tick();
    check("ml4_seg4_valid", int'(if_4.rd_valid), 0);
    ridx = 7;
    tick();
    check("grow_seg7_x", int'(if_m.rd_x), 14);
    check("grow_seg7_valid", int'(if_m.rd_valid), 1);
    ridx = 8;
    tick();
    check("grow_seg8_valid", int'(if_m.rd_valid), 0);
    ridx = 0;

    // Self-collision: grow to 5, then up, left, down into own body.
    do_reset();
    do_step(1'b1);
    do_step(1'b1);
    set_dir(DIR_UP);
    do_step(1'b0);
    set_dir(DIR_LEFT);
    do_step(1'b0);
    set_dir(DIR_DOWN);
    do_step(1'b0);
    check("self_col", int'(if_m.self_col), 1);
    check("self_dead", int'(if_m.dead), 1);
    check("self_wall", int'(if_m.wall_col), 0);
    check("self_done_count", n_done, 1);
    check("self_done_latency", lat_done, 4);
    check("self_head_x", int'(if_m.head_x), 17);
    check("self_head_y", int'(if_m.head_y), 17);
    check("self_length", int'(if_m.length), 5);
    do_step(1'b0);
    check("dead_step_done", n_done, 0);
    check("dead_step_head_x", int'(if_m.head_x), 17);
    check("dead_step_head_y", int'(if_m.head_y), 17);
    check("dead_sticky", int'(if_m.dead), 1);

    // Right edge: wrap on the default copy, wall on the WRAP=0 copy.
    do_reset();
    for (int i = 0; i < 15; i++) do_step(1'b0);
    check("edge_pre_x", int'(if_m.head_x), 31);
    check("edge_pre_x_nowrap", int'(if_w.head_x), 31);
    do_step(1'b0);
    check("wrap_head_x", int'(if_m.head_x), 0);
    check("wrap_head_y", int'(if_m.head_y), 16);
    check("wrap_dead", int'(if_m.dead), 0);
    check("wall_col", int'(if_w.wall_col), 1);
    check("wall_latency", lat_wall, 1);
    check("wall_dead", int'(if_w.dead), 1);
    check("wall_self", int'(if_w.self_col), 0);
    check("wall_head_x", int'(if_w.head_x), 31);

    // Reset asserted in the middle of a scan restores the reset body.
    do_reset();
    do_step(1'b1);
    do_step(1'b1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check("midscan_busy", int'(if_m.busy), 1);
    reset = 1'b0;
    #2;
    check("midscan_rst_length", int'(if_m.length), 3);
    check("midscan_rst_head_x", int'(if_m.head_x), 16);
    check("midscan_rst_busy", int'(if_m.busy), 0);
    tick();
    reset = 1'b1;
    tick();
    check_reset_image("midscan");
    check("midscan_done", int'(if_m.done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
